// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and default width for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate; with neg tied to the sign bit it is an abs().
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign dout = neg ? (~din + ONE) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO writes.
// Optional macro MULDIV_EARLY_TERM_EN ends multiplies once the multiplier magnitude is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;     // product accumulator, or {remainder, quotient}
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   opb;     // multiplier (shifts) or divisor (static)
  logic               is_div;
  logic               divz;
  logic               neg_res;
  logic               neg_rem;

  logic             sgn;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign sgn = op_is_signed(op);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .din (srcA),
    .neg (sgn & srcA[WIDTH-1]),
    .dout(abs_a)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .din (srcB),
    .neg (sgn & srcB[WIDTH-1]),
    .dout(abs_b)
  );

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .din (acc),
    .neg (neg_res),
    .dout(prod_fix)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .din (acc[WIDTH-1:0]),
    .neg (neg_res),
    .dout(quot_fix)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .din (acc[2*WIDTH-1:WIDTH]),
    .neg (neg_rem),
    .dout(rem_fix)
  );

  // Restoring divide step: remainder needs one spare bit after the shift, plus a borrow bit.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               calc_end;

  assign rem_sh      = acc[2*WIDTH-1:WIDTH-1];
  assign diff        = {1'b0, rem_sh} - {2'b00, opb};
  assign div_next    = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  assign mul_next    = opb[0] ? (acc + mcand) : acc;
  assign mplier_next = opb >> 1;

`ifdef MULDIV_EARLY_TERM_EN
  assign calc_end = (cnt == CNT_W'(1)) || (!is_div && (mplier_next == '0));
`else
  assign calc_end = (cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      divz    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      case (state)
        // Accept a new request; ops that need iteration latch magnitudes and signs.
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi <= srcA;
              OP_MTLO: lo <= srcA;
              OP_MULT, OP_MULTU: begin
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, abs_a};
                opb     <= abs_b;
                neg_res <= sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                neg_rem <= 1'b0;
                is_div  <= 1'b0;
                divz    <= 1'b0;
                cnt     <= CNT_W'(WIDTH);
                busy    <= 1'b1;
                state   <= ST_CALC;
              end
              OP_DIV, OP_DIVU: begin
                is_div  <= 1'b1;
                busy    <= 1'b1;
                neg_res <= sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                neg_rem <= sgn & srcA[WIDTH-1];
                opb     <= abs_b;
                cnt     <= CNT_W'(WIDTH);
                if (srcB == '0) begin
                  divz  <= 1'b1;
                  acc   <= {srcA, {WIDTH{1'b1}}};
                  state <= ST_FINISH;
                end else begin
                  divz  <= 1'b0;
                  acc   <= {{WIDTH{1'b0}}, abs_a};
                  state <= ST_CALC;
                end
              end
              default: ;
            endcase
          end
        end
        // One shift-add or shift-subtract per cycle.
        ST_CALC: begin
          if (is_div) begin
            acc <= div_next;
          end else begin
            acc   <= mul_next;
            mcand <= mcand << 1;
            opb   <= mplier_next;
          end
          cnt <= cnt - CNT_W'(1);
          if (calc_end) state <= ST_FINISH;
        end
        // Sign correction and the single HI/LO write.
        ST_FINISH: begin
          if (divz) begin
            hi <= acc[2*WIDTH-1:WIDTH];
            lo <= acc[WIDTH-1:0];
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done    <= 1'b1;
          divZero <= divz;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
